seg7_bcd_display: RTL and testbench

Parametrised multi-digit 7-segment display driver for the board HEX displays.
- Takes a WIDTH-bit unsigned binary value and shows it on DIGITS displays, in decimal (sequential double-dabble binary-to-BCD) or raw hexadecimal.
- Optional leading-zero blanking and overflow indication.
- Start/busy/done handshake.
- Registered, glitch-free segment outputs sit between datapath logic and the top-level HEX pins.

---
 rtl/seg7_pkg.sv | 33 +++
 rtl/seg7_hex_decode.sv | 32 +++
 rtl/seg7_bcd_display.sv | 151 +++++++++++++++
 tb/tb_seg7_bcd_display.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the multi-digit 7-segment display driver:
// FSM state encoding and active-low segment patterns (bit0=a .. bit6=g).
package seg7_pkg;

  localparam int unsigned NIB_W = 4;
  localparam int unsigned SEG_W = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    UPDATE = 2'd2
  } state_t;

  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_A     = 7'b0001000;
  localparam logic [SEG_W-1:0] SEG_B     = 7'b0000011;
  localparam logic [SEG_W-1:0] SEG_C     = 7'b1000110;
  localparam logic [SEG_W-1:0] SEG_D     = 7'b0100001;
  localparam logic [SEG_W-1:0] SEG_E     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_F     = 7'b0001110;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0111111;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low 7-segment pattern, full 0-F.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [NIB_W-1:0] nibble,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    case (nibble)
      4'h0: seg_c = SEG_0;
      4'h1: seg_c = SEG_1;
      4'h2: seg_c = SEG_2;
      4'h3: seg_c = SEG_3;
      4'h4: seg_c = SEG_4;
      4'h5: seg_c = SEG_5;
      4'h6: seg_c = SEG_6;
      4'h7: seg_c = SEG_7;
      4'h8: seg_c = SEG_8;
      4'h9: seg_c = SEG_9;
      4'hA: seg_c = SEG_A;
      4'hB: seg_c = SEG_B;
      4'hC: seg_c = SEG_C;
      4'hD: seg_c = SEG_D;
      4'hE: seg_c = SEG_E;
      4'hF: seg_c = SEG_F;
      default: seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_bcd_display.sv
// Multi-digit 7-segment driver: sequential double-dabble (decimal) or raw
// nibbles (hex), optional leading-zero blanking, overflow dashes, registered HEX.
module seg7_bcd_display
  import seg7_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                   Clock,
  input  logic                   Resetn,
  input  logic [WIDTH-1:0]       value,
  input  logic                   start,
  input  logic                   hex_mode,
  input  logic                   blank_lz,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  output logic [7*DIGITS-1:0]    HEX
);

  localparam int unsigned BCD_W = NIB_W * DIGITS;
  localparam int unsigned HEX_W = SEG_W * DIGITS;
  localparam int unsigned CAT_W = BCD_W + WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [BCD_W-1:0]   bcd, bcd_n, bcd_adj;
  logic [WIDTH-1:0]   bin, bin_n;
  logic               ovf, ovf_n;
  logic               mode_hex, mode_hex_n;
  logic               blank, blank_n;
  logic               busy_n, done_n, overflow_n;
  logic [HEX_W-1:0]   hex_n;
  logic [CAT_W-1:0]   dd_next, hex_ext;
  logic [BCD_W-1:0]   nib_all;
  logic [HEX_W-1:0]   seg_all, disp;
  logic               hex_ovf, disp_ovf, seen_nz;

  // One double-dabble step: add 3 to every digit >= 5, then shift {bcd, bin}.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd[NIB_W*i +: NIB_W] >= 4'd5) begin
        bcd_adj[NIB_W*i +: NIB_W] = bcd[NIB_W*i +: NIB_W] + 4'd3;
      end
    end
    dd_next = {bcd_adj, bin} << 1;
  end

  // Digit source: captured value nibbles in hex mode, BCD result otherwise.
  always_comb begin
    hex_ext  = CAT_W'(bin);
    hex_ovf  = |hex_ext[CAT_W-1:BCD_W];
    nib_all  = mode_hex ? hex_ext[BCD_W-1:0] : bcd;
    disp_ovf = mode_hex ? hex_ovf : ovf;
  end

  for (genvar g = 0; g < int'(DIGITS); g++) begin : g_dec
    seg7_hex_decode u_dec (
      .nibble (nib_all[NIB_W*g +: NIB_W]),
      .seg_c  (seg_all[SEG_W*g +: SEG_W])
    );
  end

  // Overflow dashes win; blanking walks down from the top digit, never digit 0.
  always_comb begin
    disp    = seg_all;
    seen_nz = 1'b0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      if (disp_ovf) begin
        disp[SEG_W*i +: SEG_W] = SEG_DASH;
      end else if (blank && !seen_nz && (i != 0) && (nib_all[NIB_W*i +: NIB_W] == 4'd0)) begin
        disp[SEG_W*i +: SEG_W] = SEG_BLANK;
      end
      if (nib_all[NIB_W*i +: NIB_W] != 4'd0) seen_nz = 1'b1;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    bcd_n      = bcd;
    bin_n      = bin;
    ovf_n      = ovf;
    mode_hex_n = mode_hex;
    blank_n    = blank;
    busy_n     = busy;
    done_n     = 1'b0;
    overflow_n = overflow;
    hex_n      = HEX;
    case (state)
      IDLE: begin
        if (start) begin
          bin_n      = value;
          bcd_n      = '0;
          ovf_n      = 1'b0;
          cnt_n      = '0;
          mode_hex_n = hex_mode;
          blank_n    = blank_lz;
          busy_n     = 1'b1;
          state_n    = hex_mode ? UPDATE : SHIFT;
        end
      end
      SHIFT: begin
        bcd_n = dd_next[CAT_W-1:WIDTH];
        bin_n = dd_next[WIDTH-1:0];
        ovf_n = ovf | bcd_adj[BCD_W-1];
        cnt_n = cnt + CNT_W'(1);
        if (cnt == CNT_W'(WIDTH - 1)) state_n = UPDATE;
      end
      UPDATE: begin
        hex_n      = disp;
        overflow_n = disp_ovf;
        done_n     = 1'b1;
        busy_n     = 1'b0;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state    <= IDLE;
      cnt      <= '0;
      bcd      <= '0;
      bin      <= '0;
      ovf      <= 1'b0;
      mode_hex <= 1'b0;
      blank    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      HEX      <= '1;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bcd      <= bcd_n;
      bin      <= bin_n;
      ovf      <= ovf_n;
      mode_hex <= mode_hex_n;
      blank    <= blank_n;
      busy     <= busy_n;
      done     <= done_n;
      overflow <= overflow_n;
      HEX      <= hex_n;
    end
  end

endmodule

// File: tb/tb_seg7_bcd_display.sv
// Directed bench for seg7_bcd_display: a 3-digit and a 2-digit instance
// (WIDTH=8), vector table plus hand-written handshake and reset sequences.
module tb_seg7_bcd_display;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                         S9 = 7'b0010000, SA = 7'b0001000, SB = 7'b0000011,
                         SF = 7'b0001110, BL = 7'b1111111, DA = 7'b0111111;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic [7:0]  value;
  logic        start3, start2, hex_mode, blank_lz;
  logic        busy3, done3, ovf3, busy2, done2, ovf2;
  logic [20:0] hex3;
  logic [13:0] hex2;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          d2;
    logic [7:0]  v;
    logic        hm;
    logic        blz;
    logic [20:0] exp_hex;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[15];

  always #5 Clock = ~Clock;

  seg7_bcd_display #(.WIDTH(8), .DIGITS(3)) dut3 (
    .Clock(Clock), .Resetn(Resetn), .value(value), .start(start3),
    .hex_mode(hex_mode), .blank_lz(blank_lz), .busy(busy3), .done(done3),
    .overflow(ovf3), .HEX(hex3)
  );

  seg7_bcd_display #(.WIDTH(8), .DIGITS(2)) dut2 (
    .Clock(Clock), .Resetn(Resetn), .value(value), .start(start2),
    .hex_mode(hex_mode), .blank_lz(blank_lz), .busy(busy2), .done(done2),
    .overflow(ovf2), .HEX(hex2)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [20:0] cur_hex(input bit d2);
    return d2 ? {7'd0, hex2} : hex3;
  endfunction

  // Drive start at a negedge; returns at the negedge after the accepting edge.
  task automatic start_conv(input bit d2, input logic [7:0] v, input logic hm, input logic blz);
    @(negedge Clock);
    value    = v;
    hex_mode = hm;
    blank_lz = blz;
    if (d2) start2 = 1'b1;
    else    start3 = 1'b1;
    @(negedge Clock);
    chk("busy_after_accept", 32'(d2 ? busy2 : busy3), 32'd1);
  endtask

  task automatic wait_done(input bit d2, input int j0, input int exp_j,
                           output logic [20:0] h, output logic o);
    int j;
    bit gap;
    bit seen;
    j = j0; gap = 1'b0; seen = 1'b0;
    while (!seen && j < j0 + 40) begin
      @(negedge Clock);
      j++;
      if (d2 ? done2 : done3) seen = 1'b1;
      else if (!(d2 ? busy2 : busy3)) gap = 1'b1;
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("latency", 32'(j), 32'(exp_j));
    chk("busy_low_at_done", 32'(d2 ? busy2 : busy3), 32'd0);
    chk("busy_no_gap", 32'(gap), 32'd0);
    h = cur_hex(d2);
    o = d2 ? ovf2 : ovf3;
    @(negedge Clock);
    chk("done_one_cycle", 32'(d2 ? done2 : done3), 32'd0);
  endtask

  initial begin
    logic [20:0] h;
    logic        o;
    int          cnt_done;

    vecs[0]  = '{1'b0, 8'd255,  1'b0, 1'b0, {S2, S5, S5}, 1'b0};
    vecs[1]  = '{1'b0, 8'hAB,   1'b1, 1'b0, {S0, SA, SB}, 1'b0};
    vecs[2]  = '{1'b0, 8'hAB,   1'b1, 1'b1, {BL, SA, SB}, 1'b0};
    vecs[3]  = '{1'b0, 8'd0,    1'b0, 1'b1, {BL, BL, S0}, 1'b0};
    vecs[4]  = '{1'b0, 8'd7,    1'b0, 1'b1, {BL, BL, S7}, 1'b0};
    vecs[5]  = '{1'b1, 8'd100,  1'b0, 1'b0, {7'd0, DA, DA}, 1'b1};
    vecs[6]  = '{1'b1, 8'd99,   1'b0, 1'b0, {7'd0, S9, S9}, 1'b0};
    vecs[7]  = '{1'b0, 8'd42,   1'b0, 1'b0, {S0, S4, S2}, 1'b0};
    vecs[8]  = '{1'b0, 8'h05,   1'b1, 1'b1, {BL, BL, S5}, 1'b0};
    vecs[9]  = '{1'b1, 8'hAB,   1'b1, 1'b0, {7'd0, SA, SB}, 1'b0};
    vecs[10] = '{1'b0, 8'hFF,   1'b1, 1'b1, {BL, SF, SF}, 1'b0};
    vecs[11] = '{1'b0, 8'd100,  1'b0, 1'b1, {S1, S0, S0}, 1'b0};
    vecs[12] = '{1'b0, 8'd10,   1'b0, 1'b1, {BL, S1, S0}, 1'b0};
    vecs[13] = '{1'b1, 8'd200,  1'b0, 1'b1, {7'd0, DA, DA}, 1'b1};
    vecs[14] = '{1'b0, 8'h00,   1'b1, 1'b0, {S0, S0, S0}, 1'b0};

    Resetn = 1'b0; value = '0; start3 = 1'b0; start2 = 1'b0;
    hex_mode = 1'b0; blank_lz = 1'b0;
    repeat (2) @(negedge Clock);
    chk("rst_hex3", 32'(hex3), 32'h1FFFFF);
    chk("rst_hex2", 32'(hex2), 32'h3FFF);
    chk("rst_busy", 32'(busy3), 32'd0);
    chk("rst_done", 32'(done3), 32'd0);
    chk("rst_ovf",  32'(ovf3),  32'd0);
    Resetn = 1'b1;

    for (int i = 0; i < 15; i++) begin
      start_conv(vecs[i].d2, vecs[i].v, vecs[i].hm, vecs[i].blz);
      start3 = 1'b0; start2 = 1'b0;
      wait_done(vecs[i].d2, 0, vecs[i].hm ? 2 - 1 : 9, h, o);
      chk($sformatf("vec%0d_hex", i), 32'(h), 32'(vecs[i].exp_hex));
      chk($sformatf("vec%0d_ovf", i), 32'(o), 32'(vecs[i].exp_ovf));
    end

    // start re-pulsed mid-SHIFT with a different value is ignored
    start_conv(1'b0, 8'd123, 1'b0, 1'b0);
    start3 = 1'b0;
    @(negedge Clock);
    value = 8'd200; start3 = 1'b1;
    @(negedge Clock);
    start3 = 1'b0;
    wait_done(1'b0, 2, 9, h, o);
    chk("ignored_start_hex", 32'(h), 32'({S1, S2, S3}));
    cnt_done = 0;
    repeat (12) begin
      @(negedge Clock);
      if (done3) cnt_done++;
    end
    chk("ignored_start_no_extra_done", 32'(cnt_done), 32'd0);
    chk("ignored_start_idle", 32'(busy3), 32'd0);

    // start held high through done: second conversion accepted in the done cycle
    start_conv(1'b0, 8'd56, 1'b0, 1'b0);
    value = 8'd78;
    wait_done(1'b0, 0, 9, h, o);
    chk("b2b_first_hex", 32'(h), 32'({S0, S5, S6}));
    chk("b2b_busy", 32'(busy3), 32'd1);
    start3 = 1'b0;
    wait_done(1'b0, 0, 9, h, o);
    chk("b2b_second_hex", 32'(h), 32'({S0, S7, S8}));

    // asynchronous reset in the middle of SHIFT
    start_conv(1'b0, 8'd255, 1'b0, 1'b0);
    start3 = 1'b0;
    repeat (3) @(negedge Clock);
    Resetn = 1'b0;
    #1;
    chk("midrst_hex", 32'(hex3), 32'h1FFFFF);
    chk("midrst_busy", 32'(busy3), 32'd0);
    chk("midrst_done", 32'(done3), 32'd0);
    repeat (2) @(negedge Clock);
    Resetn = 1'b1;
    cnt_done = 0;
    repeat (15) begin
      @(negedge Clock);
      if (done3) cnt_done++;
    end
    chk("midrst_no_done", 32'(cnt_done), 32'd0);
    chk("midrst_hex_held", 32'(hex3), 32'h1FFFFF);
    start_conv(1'b0, 8'd42, 1'b0, 1'b0);
    start3 = 1'b0;
    wait_done(1'b0, 0, 9, h, o);
    chk("post_rst_hex", 32'(h), 32'({S0, S4, S2}));
    chk("post_rst_ovf", 32'(o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
